// File: rtl/pwl_interp_unit.sv
// pwl_interp_unit
//   Piecewise-linear interpolator for ROM-tabulated functions, for example
//   h(u) = sqrt(-2 ln u) * 2^11 in the Box-Muller datapath. The upper address
//   bits select segment i. The lower FRAC_W bits interpolate between entries
//   i and i+1 using a signed slope, so both rising and falling tables work.
//   The dual-port ROM sits outside this block.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   in_valid/in_ready       address handshake (ready only in IDLE)
//   in_addr[ADDR_W]         {segment index, fraction}
//   rom_addr_a/b[SEG_W]     ROM addresses for entry i and entry i+1
//                           (entry i+1 is clamped to i in the top segment)
//   rom_data_a/b[DATA_W]    ROM read data, ROM_LAT cycles after the address
//   out_valid/out_ready     result handshake
//   out_data[DATA_W]        interpolated, clamped result (unsigned)
//   busy                    high whenever the FSM is not in IDLE
module pwl_interp_unit #(
  parameter int ADDR_W  = 16,
  parameter int SEG_W   = 11,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = 1,
  parameter int ROUND   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic [SEG_W-1:0]  rom_addr_a,
  output logic [SEG_W-1:0]  rom_addr_b,
  input  logic [DATA_W-1:0] rom_data_a,
  input  logic [DATA_W-1:0] rom_data_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int FRAC_W = ADDR_W - SEG_W;
  localparam int PW     = DATA_W + FRAC_W + 2;  // product width
  localparam int QW     = PW - FRAC_W;          // interpolation term width
  localparam int YW     = DATA_W + 3;           // sum width before clamping
  localparam int CNT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic signed [PW-1:0] RND_BIAS =
    (ROUND != 0) ? PW'(1 << (FRAC_W - 1)) : PW'(0);

  typedef enum logic [2:0] {IDLE, FETCH, CALC, SUM, HOLD} state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]        wait_cnt;
  logic [SEG_W-1:0]        idx_in;
  logic [FRAC_W-1:0]       frac_p0;
  logic signed [DATA_W:0]  diff;
  logic signed [PW-1:0]    prod;
  logic [DATA_W-1:0]       y0_p1;
  logic signed [PW-1:0]    prod_p1;
  logic signed [QW-1:0]    q_p1;
  logic signed [YW-1:0]    y_sum;

  // Adds the optional half-LSB bias, then drops FRAC_W bits. Dropping the
  // low bits of a two's-complement value is an arithmetic shift, which
  // rounds toward -inf. With the bias added, ties round toward +inf.
  function automatic logic signed [QW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] biased;
    biased = p + RND_BIAS;
    return $signed(biased[PW-1:FRAC_W]);
  endfunction

  // Clamps a signed sum into the unsigned output range [0, 2^DATA_W-1].
  function automatic logic [DATA_W-1:0] sat_u(input logic signed [YW-1:0] y);
    logic [DATA_W-1:0] r;
    if (y[YW-1]) begin
      r = '0;
    end else if (|y[YW-2:DATA_W]) begin
      r = '1;
    end else begin
      r = y[DATA_W-1:0];
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (wait_cnt == '0) begin
          state_nxt = CALC;
        end
      end
      CALC: state_nxt = SUM;
      SUM:  state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idx_in = in_addr[ADDR_W-1:FRAC_W];
    diff   = $signed({1'b0, rom_data_b}) - $signed({1'b0, rom_data_a});
    prod   = $signed({{(FRAC_W + 1){diff[DATA_W]}}, diff})
           * $signed({{(DATA_W + 2){1'b0}}, frac_p0});
    q_p1   = round_shift(prod_p1);
    y_sum  = $signed({3'b000, y0_p1}) + $signed({q_p1[QW-1], q_p1});
  end

  // Stage 0: accept an address. Latch the ROM addresses and the fraction,
  // and start the ROM wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt   <= '0;
      rom_addr_a <= '0;
      rom_addr_b <= '0;
      out_data   <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        wait_cnt   <= CNT_W'(ROM_LAT - 1);
        rom_addr_a <= idx_in;
        rom_addr_b <= (&idx_in) ? idx_in : idx_in + SEG_W'(1);
      end else if (state == FETCH && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
      // Stage 2: round, add and clamp into the held output register.
      if (state == SUM) begin
        out_data <= sat_u(y_sum);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      frac_p0 <= in_addr[FRAC_W-1:0];
    end
    // Stage 1: ROM data is valid in CALC. Capture the base entry and the
    // slope-times-fraction product.
    if (state == CALC) begin
      y0_p1   <= rom_data_a;
      prod_p1 <= prod;
    end
  end

endmodule

// File: tb/tb_pwl_interp_unit.sv
// Bench for pwl_interp_unit. It runs three builds side by side on one shared
// stimulus:
//   0: ROM_LAT=1, ROUND=1
//   1: ROM_LAT=1, ROUND=0
//   2: ROM_LAT=3, ROUND=1
// Each build has its own ROM read pipeline and its own expected-result queue.
module tb_pwl_interp_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_addr;
  logic        out_ready;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  busy;
  logic [10:0] rom_addr_a [3];
  logic [10:0] rom_addr_b [3];
  logic [15:0] rom_data_a [3];
  logic [15:0] rom_data_b [3];
  logic [15:0] out_data   [3];
  logic [15:0] rom        [2048];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc [3];
  logic [2:0] prev_ov = 3'b000;
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int RND = (g == 1) ? 0 : 1;
    logic [15:0] pa [LAT];
    logic [15:0] pb [LAT];
    always @(posedge clk) begin
      pa[0] <= rom[rom_addr_a[g]];
      pb[0] <= rom[rom_addr_b[g]];
      for (int k = 1; k < LAT; k++) begin
        pa[k] <= pa[k-1];
        pb[k] <= pb[k-1];
      end
    end
    assign rom_data_a[g] = pa[LAT-1];
    assign rom_data_b[g] = pb[LAT-1];

    pwl_interp_unit #(
      .ADDR_W(16), .SEG_W(11), .DATA_W(16), .ROM_LAT(LAT), .ROUND(RND)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready[g]),
      .in_addr    (in_addr),
      .rom_addr_a (rom_addr_a[g]),
      .rom_addr_b (rom_addr_b[g]),
      .rom_data_a (rom_data_a[g]),
      .rom_data_b (rom_data_b[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready),
      .out_data   (out_data[g]),
      .busy       (busy[g])
    );
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: y = floor(a + (b-a)*frac/32 + bias), computed with real
  // arithmetic and then clamped to 16 bits.
  function automatic logic [15:0] model(input logic [15:0] addr, input bit rnd);
    int idx, fr, a, b, y;
    real v;
    idx = int'(addr[15:5]);
    fr  = int'(addr[4:0]);
    a   = int'(rom[idx]);
    b   = (idx == 2047) ? a : int'(rom[idx+1]);
    v   = real'(a) + real'((b - a) * fr) / 32.0 + (rnd ? 0.5 : 0.0);
    y   = $rtoi($floor(v));
    if (y < 0) y = 0;
    if (y > 65535) y = 65535;
    return 16'(y);
  endfunction

  // Monitor: checks latency on each rising out_valid and pops the
  // scoreboard on every output handshake.
  always @(negedge clk) begin
    int n;
    logic [15:0] e;
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        if (in_valid && in_ready[i]) acc[i] = cyc + 1;
        if (out_valid[i] && !prev_ov[i])
          check_val($sformatf("latency%0d", i), 32'(cyc - acc[i]), (i == 2) ? 32'd5 : 32'd3);
        if (out_valid[i] && out_ready) begin
          n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
          check_val($sformatf("expected_pending%0d", i), 32'(n > 0), 32'd1);
          if (n > 0) begin
            if (i == 0) e = q0.pop_front();
            else if (i == 1) e = q1.pop_front();
            else e = q2.pop_front();
            check_val($sformatf("out_data%0d", i), 32'(out_data[i]), 32'(e));
          end
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic wait_idle();
    int t = 0;
    while (in_ready !== 3'b111 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check_val("idle_timeout", 32'(in_ready), 32'h7);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) check_val("drain_timeout", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  task automatic send(input logic [15:0] addr, input logic [15:0] e0, input logic [15:0] e1,
                      input logic [15:0] e2, input logic [10:0] ra, input logic [10:0] rb,
                      input bit chk_addr);
    wait_idle();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_addr  = addr;
    q0.push_back(e0);
    q1.push_back(e1);
    q2.push_back(e2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (chk_addr) begin
      check_val("rom_addr_a0", 32'(rom_addr_a[0]), 32'(ra));
      check_val("rom_addr_b0", 32'(rom_addr_b[0]), 32'(rb));
      check_val("rom_addr_a2", 32'(rom_addr_a[2]), 32'(ra));
      check_val("rom_addr_b2", 32'(rom_addr_b[2]), 32'(rb));
    end
    wait_drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_addr   = 16'h0000;
    out_ready = 1'b1;
    for (int a = 0; a < 2048; a++) rom[a] = 16'($urandom);
    rom[5]    = 16'h2000;
    rom[6]    = 16'h1FE0;
    rom[7]    = 16'h0100;
    rom[8]    = 16'h0103;
    rom[9]    = 16'h0100;
    rom[100]  = 16'h1000;
    rom[101]  = 16'h1020;
    rom[2047] = 16'h0042;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'h7);
    check_val("rst_out_valid", 32'(out_valid), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_out_data0", 32'(out_data[0]), 32'h0);
    check_val("rst_out_data2", 32'(out_data[2]), 32'h0);
    check_val("rst_rom_addr_a", 32'(rom_addr_a[0]), 32'h0);
    check_val("rst_rom_addr_b", 32'(rom_addr_b[0]), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    send(16'h0C90, 16'h1010, 16'h1010, 16'h1010, 11'd100, 11'd101, 1'b1);
    send(16'h00A8, 16'h1FF8, 16'h1FF8, 16'h1FF8, 11'd5, 11'd6, 1'b1);
    send(16'h00A0, 16'h2000, 16'h2000, 16'h2000, 11'd5, 11'd6, 1'b0);
    send(16'h00F0, 16'h0102, 16'h0101, 16'h0102, 11'd7, 11'd8, 1'b1);
    send(16'h0110, 16'h0102, 16'h0101, 16'h0102, 11'd8, 11'd9, 1'b1);
    send(16'hFFFF, 16'h0042, 16'h0042, 16'h0042, 11'd2047, 11'd2047, 1'b1);

    // Backpressure: hold the result while ignoring in_valid pulses.
    wait_idle();
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_addr  = 16'h0C90;
    q0.push_back(16'h1010);
    q1.push_back(16'h1010);
    q2.push_back(16'h1010);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 0; t < 20 && out_valid !== 3'b111; t++) begin
      @(posedge clk); #1;
    end
    check_val("bp_valid", 32'(out_valid), 32'h7);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_addr  = 16'h00A8;
      @(posedge clk); #1;
      check_val("bp_hold_data0", 32'(out_data[0]), 32'h1010);
      check_val("bp_hold_data2", 32'(out_data[2]), 32'h1010);
      check_val("bp_in_ready", 32'(in_ready), 32'h0);
      check_val("bp_busy", 32'(busy), 32'h7);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_valid", 32'(out_valid), 32'h0);
    check_val("bp_release_ready", 32'(in_ready), 32'h7);
    check_val("bp_data_kept", 32'(out_data[0]), 32'h1010);
    wait_drain();

    // Abort: reset while every build is in FETCH.
    wait_idle();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_addr  = 16'h00A8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("abort_busy_before", 32'(busy), 32'h7);
    reset = 1'b1;
    #1;
    check_val("abort_out_valid", 32'(out_valid), 32'h0);
    check_val("abort_in_ready", 32'(in_ready), 32'h7);
    check_val("abort_busy", 32'(busy), 32'h0);
    check_val("abort_out_data0", 32'(out_data[0]), 32'h0);
    check_val("abort_out_data2", 32'(out_data[2]), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    send(16'h0C90, 16'h1010, 16'h1010, 16'h1010, 11'd100, 11'd101, 1'b1);

    // Random segments against the reference model.
    for (int r = 0; r < 8; r++) begin
      ra = 16'($urandom);
      send(ra, model(ra, 1'b1), model(ra, 1'b0), model(ra, 1'b1), 11'd0, 11'd0, 1'b0);
    end

    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
